tx_arbiter: RTL

//  Shares the single NSHIFT-bit serial TX channel between two requesters: the scheduler (memory read/write and PC-write prefetch commands) and the prefetcher (sequential imm/instruction reads).

---
 rtl/tx_arbiter_pkg.sv | 26 ++
 rtl/tx_arbiter_serializer.sv | 76 +++++++
 rtl/tx_arbiter.sv | 91 +++++++++
 3 files changed

// File: rtl/tx_arbiter_pkg.sv
// Shared constants for the TX channel arbiter: header codes, serializer states
// and the grant record captured when a requester wins the channel.
package tx_arbiter_pkg;

  localparam int TX_CMD_BITS = 2;

  // Header codes avoid 2'b11 so a header is never mistaken for the idle level.
  localparam logic [TX_CMD_BITS-1:0] TX_HEADER_READ_16  = 2'b00;
  localparam logic [TX_CMD_BITS-1:0] TX_HEADER_WRITE_16 = 2'b01;
  localparam logic [TX_CMD_BITS-1:0] TX_HEADER_WRITE_8  = 2'b10;

  localparam logic [1:0] TX_STATE_IDLE    = 2'd0;
  localparam logic [1:0] TX_STATE_HEADER  = 2'd1;
  localparam logic [1:0] TX_STATE_PAYLOAD = 2'd2;

  typedef struct packed {
    logic                   owner_sch;
    logic [TX_CMD_BITS-1:0] cmd;
  } tx_grant_t;

  function automatic int unsigned tx_payload_len(input logic [TX_CMD_BITS-1:0] cmd,
                                                 input int unsigned full_cycles);
    return (cmd == TX_HEADER_WRITE_8) ? full_cycles / 2 : full_cycles;
  endfunction

endpackage

// File: rtl/tx_arbiter_serializer.sv
// Header/payload sequencer for the TX pins: one header cycle, then N payload
// cycles with a running index; o_ready marks cycles in which a new grant may land.
module tx_serializer
  import tx_arbiter_pkg::*;
#(
  parameter int NSHIFT         = 2,
  parameter int PAYLOAD_CYCLES = 8,
  parameter int CW             = $clog2(PAYLOAD_CYCLES) + 1
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   i_grant,
  input  logic [TX_CMD_BITS-1:0] i_cmd,
  input  logic [NSHIFT-1:0]      i_payload,
  output logic                   o_ready,
  output logic                   o_active,
  output logic                   o_data_next,
  output logic                   o_done,
  output logic [CW-1:0]          o_counter,
  output logic [NSHIFT-1:0]      o_pins
);

  logic [1:0]             r_state;
  logic [TX_CMD_BITS-1:0] r_cmd;
  logic [CW-1:0]          r_count;
  logic [CW-1:0]          w_len;
  logic                   w_last;

  assign w_len  = CW'(tx_payload_len(r_cmd, PAYLOAD_CYCLES));
  assign w_last = (r_state == TX_STATE_PAYLOAD) && (r_count == w_len - CW'(1));

  // Gating with reset_n keeps the *_started pulses low while reset is held.
  assign o_ready     = reset_n && ((r_state == TX_STATE_IDLE) || w_last);
  assign o_active    = (r_state != TX_STATE_IDLE);
  assign o_data_next = (r_state == TX_STATE_PAYLOAD);
  assign o_done      = w_last;
  assign o_counter   = r_count;

  always_comb begin
    o_pins = '1;
    if (r_state == TX_STATE_HEADER)       o_pins = NSHIFT'(r_cmd);
    else if (r_state == TX_STATE_PAYLOAD) o_pins = i_payload;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= TX_STATE_IDLE;
      r_cmd   <= TX_HEADER_READ_16;
      r_count <= '0;
    end else if (i_grant) begin
      r_state <= TX_STATE_HEADER;
      r_cmd   <= i_cmd;
      r_count <= '0;
    end else begin
      case (r_state)
        TX_STATE_HEADER: begin
          r_state <= TX_STATE_PAYLOAD;
          r_count <= '0;
        end
        TX_STATE_PAYLOAD: begin
          if (w_last) begin
            r_state <= TX_STATE_IDLE;
            r_count <= '0;
          end else begin
            r_count <= r_count + CW'(1);
          end
        end
        default: begin
          r_state <= TX_STATE_IDLE;
          r_count <= '0;
        end
      endcase
    end
  end

endmodule

// File: rtl/tx_arbiter.sv
// Shares the serial TX channel between scheduler and prefetcher and drives the
// owner handshake. Define TX_ARB_ROUND_ROBIN_EN to alternate grants on contention.
module tx_arbiter
  import tx_arbiter_pkg::*;
#(
  parameter int NSHIFT         = 2,
  parameter int PAYLOAD_CYCLES = 8
) (
  input  logic                               clk,
  input  logic                               reset_n,
  input  logic                               sch_valid,
  input  logic [TX_CMD_BITS-1:0]             sch_cmd,
  input  logic                               sch_reserve,
  input  logic [NSHIFT-1:0]                  sch_data,
  input  logic                               pf_valid,
  input  logic [NSHIFT-1:0]                  pf_data,
  output logic                               sch_started,
  output logic                               pf_started,
  output logic                               owner_sch,
  output logic                               tx_active,
  output logic                               tx_data_next,
  output logic [$clog2(PAYLOAD_CYCLES):0]    tx_counter,
  output logic                               tx_done,
  output logic [NSHIFT-1:0]                  tx_pins
);

  logic      w_ready;
  logic      w_pf_eligible;
  logic      w_sch_grant;
  logic      w_pf_grant;
  logic      r_owner_sch;
  tx_grant_t w_grant;

  assign w_pf_eligible = pf_valid && !sch_reserve;

`ifdef TX_ARB_ROUND_ROBIN_EN
  logic r_rr_sch;

  always_comb begin
    w_sch_grant = 1'b0;
    w_pf_grant  = 1'b0;
    if (sch_valid && w_pf_eligible) begin
      w_sch_grant = w_ready && r_rr_sch;
      w_pf_grant  = w_ready && !r_rr_sch;
    end else begin
      w_sch_grant = w_ready && sch_valid;
      w_pf_grant  = w_ready && w_pf_eligible;
    end
  end

  // Pointer always moves to the requester that did not just win.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)         r_rr_sch <= 1'b1;
    else if (w_sch_grant) r_rr_sch <= 1'b0;
    else if (w_pf_grant)  r_rr_sch <= 1'b1;
  end
`else
  assign w_sch_grant = w_ready && sch_valid;
  assign w_pf_grant  = w_ready && w_pf_eligible && !sch_valid;
`endif

  assign w_grant.owner_sch = w_sch_grant;
  assign w_grant.cmd       = w_sch_grant ? sch_cmd : TX_HEADER_READ_16;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)                       r_owner_sch <= 1'b0;
    else if (w_sch_grant || w_pf_grant) r_owner_sch <= w_grant.owner_sch;
  end

  assign sch_started = w_sch_grant;
  assign pf_started  = w_pf_grant;
  assign owner_sch   = r_owner_sch;

  tx_serializer #(
    .NSHIFT        (NSHIFT),
    .PAYLOAD_CYCLES(PAYLOAD_CYCLES)
  ) u_serializer (
    .clk        (clk),
    .reset_n    (reset_n),
    .i_grant    (w_sch_grant || w_pf_grant),
    .i_cmd      (w_grant.cmd),
    .i_payload  (r_owner_sch ? sch_data : pf_data),
    .o_ready    (w_ready),
    .o_active   (tx_active),
    .o_data_next(tx_data_next),
    .o_done     (tx_done),
    .o_counter  (tx_counter),
    .o_pins     (tx_pins)
  );

endmodule
